// File: rtl/hram_arbiter.sv
// Two-port arbiter in front of hyper_xface: grants one requester per transaction,
// watches hx_busy and returns done/err plus read data. Define HRAM_ARB_FIXED_PRIO_EN for p0 fixed priority.
module hram_arbiter #(
  parameter int BUSY_TMO = 15
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        p0_req,
  input  logic        p1_req,
  input  logic        p0_we,
  input  logic        p1_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p0_wdata,
  input  logic [31:0] p1_wdata,
  output logic        p0_gnt,
  output logic        p1_gnt,
  output logic        p0_done,
  output logic        p1_done,
  output logic        p0_err,
  output logic        p1_err,
  output logic [31:0] p0_rdata,
  output logic [31:0] p1_rdata,
  output logic        hx_rd_req,
  output logic        hx_wr_req,
  output logic [31:0] hx_addr,
  output logic [31:0] hx_wr_d,
  input  logic        hx_busy,
  input  logic        hx_rd_rdy,
  input  logic [31:0] hx_rd_d
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ARMED, S_RUN, S_DONE} state_t;

  localparam logic [7:0] TMO = 8'(BUSY_TMO);

  state_t      r_state, w_state;
  logic        r_owner, w_owner;
  logic        r_we, w_we;
  logic [7:0]  r_cnt, w_cnt;
  logic [31:0] r_addr, w_addr, r_wd, w_wd;
  logic [31:0] r_rdata0, w_rdata0, r_rdata1, w_rdata1;
  logic        r_gnt0, w_gnt0, r_gnt1, w_gnt1;
  logic        r_done0, w_done0, r_done1, w_done1;
  logic        r_err0, w_err0, r_err1, w_err1;
  logic        r_rd_req, w_rd_req, r_wr_req, w_wr_req;
  logic        w_win;
`ifdef HRAM_ARB_FIXED_PRIO_EN
`else
  logic        r_last, w_last;
`endif

  always_comb begin
    w_state  = r_state;
    w_owner  = r_owner;
    w_we     = r_we;
    w_cnt    = r_cnt;
    w_addr   = r_addr;
    w_wd     = r_wd;
    w_rdata0 = r_rdata0;
    w_rdata1 = r_rdata1;
    w_gnt0   = 1'b0;
    w_gnt1   = 1'b0;
    w_done0  = 1'b0;
    w_done1  = 1'b0;
    w_err0   = 1'b0;
    w_err1   = 1'b0;
    w_rd_req = 1'b0;
    w_wr_req = 1'b0;
`ifdef HRAM_ARB_FIXED_PRIO_EN
    w_win    = !p0_req;
`else
    w_last   = r_last;
    // on a tie the port not served last wins; a lone request always wins
    w_win    = (p0_req && p1_req) ? !r_last : p1_req;
`endif
    case (r_state)
      S_IDLE: begin
        if ((p0_req || p1_req) && !hx_busy) begin
          w_state  = S_ISSUE;
          w_owner  = w_win;
          w_we     = w_win ? p1_we    : p0_we;
          w_addr   = w_win ? p1_addr  : p0_addr;
          w_wd     = w_win ? p1_wdata : p0_wdata;
          w_gnt0   = !w_win;
          w_gnt1   = w_win;
          w_wr_req = w_we;
          w_rd_req = !w_we;
`ifdef HRAM_ARB_FIXED_PRIO_EN
`else
          w_last   = w_win;
`endif
        end
      end
      S_ISSUE: begin
        w_state = S_ARMED;
        w_cnt   = 8'd0;
      end
      S_ARMED: begin
        if (hx_busy) begin
          w_state = S_RUN;
        end else begin
          w_cnt = r_cnt + 8'd1;
          if (w_cnt == TMO) begin
            w_state = S_DONE;
            w_err0  = !r_owner;
            w_err1  = r_owner;
          end
        end
      end
      S_RUN: begin
        if (hx_rd_rdy && !r_we) begin
          if (r_owner) w_rdata1 = hx_rd_d;
          else         w_rdata0 = hx_rd_d;
        end
        if (!hx_busy) begin
          w_state = S_DONE;
          w_done0 = !r_owner;
          w_done1 = r_owner;
        end
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_owner  <= 1'b0;
      r_we     <= 1'b0;
      r_cnt    <= 8'd0;
      r_addr   <= 32'd0;
      r_wd     <= 32'd0;
      r_rdata0 <= 32'd0;
      r_rdata1 <= 32'd0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      r_rd_req <= 1'b0;
      r_wr_req <= 1'b0;
`ifdef HRAM_ARB_FIXED_PRIO_EN
`else
      r_last   <= 1'b1;
`endif
    end else begin
      r_state  <= w_state;
      r_owner  <= w_owner;
      r_we     <= w_we;
      r_cnt    <= w_cnt;
      r_addr   <= w_addr;
      r_wd     <= w_wd;
      r_rdata0 <= w_rdata0;
      r_rdata1 <= w_rdata1;
      r_gnt0   <= w_gnt0;
      r_gnt1   <= w_gnt1;
      r_done0  <= w_done0;
      r_done1  <= w_done1;
      r_err0   <= w_err0;
      r_err1   <= w_err1;
      r_rd_req <= w_rd_req;
      r_wr_req <= w_wr_req;
`ifdef HRAM_ARB_FIXED_PRIO_EN
`else
      r_last   <= w_last;
`endif
    end
  end

  assign p0_gnt    = r_gnt0;
  assign p1_gnt    = r_gnt1;
  assign p0_done   = r_done0;
  assign p1_done   = r_done1;
  assign p0_err    = r_err0;
  assign p1_err    = r_err1;
  assign p0_rdata  = r_rdata0;
  assign p1_rdata  = r_rdata1;
  assign hx_rd_req = r_rd_req;
  assign hx_wr_req = r_wr_req;
  assign hx_addr   = r_addr;
  assign hx_wr_d   = r_wd;

endmodule

// File: tb/tb_hram_arbiter.sv
// Directed bench for hram_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_hram_arbiter;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        p0_req = 1'b0, p1_req = 1'b0, p0_we = 1'b0, p1_we = 1'b0;
  logic [31:0] p0_addr = '0, p1_addr = '0, p0_wdata = '0, p1_wdata = '0;
  logic        p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        hx_rd_req, hx_wr_req;
  logic [31:0] hx_addr, hx_wr_d;
  logic        hx_busy = 1'b0, hx_rd_rdy = 1'b0;
  logic [31:0] hx_rd_d = '0;

  int n_cmp = 0;
  int n_bad = 0;

  // {p0_gnt, p1_gnt, hx_wr_req, hx_rd_req} and {p0_done, p0_err, p1_done, p1_err}
  logic [3:0] t_iss, t_end;
  assign t_iss = {p0_gnt, p1_gnt, hx_wr_req, hx_rd_req};
  assign t_end = {p0_done, p0_err, p1_done, p1_err};

  hram_arbiter #(.BUSY_TMO(15)) dut (
    .clk(clk), .rstn(rstn),
    .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
    .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_done(p0_done), .p1_done(p1_done),
    .p0_err(p0_err), .p1_err(p1_err), .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .hx_rd_req(hx_rd_req), .hx_wr_req(hx_wr_req), .hx_addr(hx_addr), .hx_wr_d(hx_wr_d),
    .hx_busy(hx_busy), .hx_rd_rdy(hx_rd_rdy), .hx_rd_d(hx_rd_d)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // Plays hyper_xface from the ISSUE cycle: busy for nbusy edges, one rd_rdy beat; returns in DONE.
  task automatic hx_serve(input logic [31:0] d, input int nbusy);
    hx_busy = 1'b1;
    tick(); tick();
    hx_rd_rdy = 1'b1; hx_rd_d = d;
    tick();
    hx_rd_rdy = 1'b0;
    repeat (nbusy - 3) tick();
    hx_busy = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    n_cmp++;
    if ({t_iss, t_end} !== 8'h00) begin n_bad++; $display("FAIL reset_strobes: got %b want 00000000", {t_iss, t_end}); end
    n_cmp++;
    if ({hx_addr, hx_wr_d, p0_rdata, p1_rdata} !== 128'd0) begin
      n_bad++; $display("FAIL reset_data: got %h %h %h %h want zeros", hx_addr, hx_wr_d, p0_rdata, p1_rdata);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_write();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h10; p0_wdata = 32'hDEADBEEF;
    tick();
    n_cmp++;
    if (t_iss !== 4'b1010) begin n_bad++; $display("FAIL wr_issue: got %b want 1010", t_iss); end
    n_cmp++;
    if ({hx_addr, hx_wr_d} !== {32'h10, 32'hDEADBEEF}) begin
      n_bad++; $display("FAIL wr_hx: got %h %h want 00000010 deadbeef", hx_addr, hx_wr_d);
    end
    p0_addr = 32'hFFFFFFFF; p0_wdata = 32'h0;
    hx_serve(32'hBAD0BAD0, 6);
    n_cmp++;
    if (t_end !== 4'b1000) begin n_bad++; $display("FAIL wr_done: got %b want 1000", t_end); end
    n_cmp++;
    if ({hx_addr, hx_wr_d} !== {32'h10, 32'hDEADBEEF}) begin
      n_bad++; $display("FAIL wr_hold: got %h %h want 00000010 deadbeef", hx_addr, hx_wr_d);
    end
    n_cmp++;
    if (p0_rdata !== 32'h0) begin n_bad++; $display("FAIL wr_rdata: got %h want 00000000", p0_rdata); end
    p0_req = 1'b0;
    tick();
    n_cmp++;
    if (t_end !== 4'b0000) begin n_bad++; $display("FAIL wr_pulse: got %b want 0000", t_end); end
  endtask

  task automatic test_read();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h30;
    tick();
    n_cmp++;
    if (t_iss !== 4'b1001) begin n_bad++; $display("FAIL rd0_issue: got %b want 1001", t_iss); end
    hx_serve(32'hA5A50001, 4);
    n_cmp++;
    if ({t_end, p0_rdata} !== {4'b1000, 32'hA5A50001}) begin
      n_bad++; $display("FAIL rd0_done: got %b %h want 1000 a5a50001", t_end, p0_rdata);
    end
    p0_req = 1'b0;
    tick();
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h20;
    tick();
    n_cmp++;
    if ({t_iss, hx_addr} !== {4'b0101, 32'h20}) begin
      n_bad++; $display("FAIL rd1_issue: got %b %h want 0101 00000020", t_iss, hx_addr);
    end
    hx_serve(32'h12345678, 3);
    n_cmp++;
    if (t_end !== 4'b0010) begin n_bad++; $display("FAIL rd1_done: got %b want 0010", t_end); end
    n_cmp++;
    if ({p1_rdata, p0_rdata} !== {32'h12345678, 32'hA5A50001}) begin
      n_bad++; $display("FAIL rd1_rdata: got %h %h want 12345678 a5a50001", p1_rdata, p0_rdata);
    end
    p1_req = 1'b0;
    tick();
  endtask

  task automatic test_busy_hold();
    hx_busy = 1'b1;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h40;
    tick(); tick();
    n_cmp++;
    if (t_iss !== 4'b0000) begin n_bad++; $display("FAIL busy_hold: got %b want 0000", t_iss); end
    p0_req = 1'b0;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h50; p1_wdata = 32'h55;
    hx_busy = 1'b0;
    tick();
    n_cmp++;
    if ({t_iss, hx_addr, hx_wr_d} !== {4'b0110, 32'h50, 32'h55}) begin
      n_bad++; $display("FAIL drop_pre_gnt: got %b %h %h want 0110 00000050 00000055", t_iss, hx_addr, hx_wr_d);
    end
    hx_serve(32'h0, 3);
    n_cmp++;
    if ({t_end, p1_rdata} !== {4'b0010, 32'h12345678}) begin
      n_bad++; $display("FAIL wr1_done: got %b %h want 0010 12345678", t_end, p1_rdata);
    end
    p1_req = 1'b0;
    tick();
  endtask

  task automatic test_arbitration();
    logic [1:0]  exp_g;
    logic [31:0] exp_p1;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h100; p0_wdata = 32'h11;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      tick();
`ifdef HRAM_ARB_FIXED_PRIO_EN
      exp_g = 2'b10;
`else
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
`endif
      n_cmp++;
      if ({p0_gnt, p1_gnt, hx_addr} !== {exp_g, (exp_g[1] ? 32'h100 : 32'h200)}) begin
        n_bad++; $display("FAIL arb_gnt%0d: got %b %h want %b", i, {p0_gnt, p1_gnt}, hx_addr, exp_g);
      end
      hx_serve(32'h200 + 32'(i), 3);
      tick();
    end
    p0_req = 1'b0; p1_req = 1'b0;
`ifdef HRAM_ARB_FIXED_PRIO_EN
    exp_p1 = 32'h0;
`else
    exp_p1 = 32'h203;
`endif
    n_cmp++;
    if ({p1_rdata, p0_rdata} !== {exp_p1, 32'h0}) begin
      n_bad++; $display("FAIL arb_rdata: got %h %h want %h 00000000", p1_rdata, p0_rdata, exp_p1);
    end
    tick();
  endtask

  task automatic test_timeout();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h60;
    tick();
    n_cmp++;
    if (t_iss !== 4'b1001) begin n_bad++; $display("FAIL tmo_issue: got %b want 1001", t_iss); end
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_cmp++;
      if (t_end !== ((k == 16) ? 4'b0100 : 4'b0000)) begin
        n_bad++; $display("FAIL tmo_cycle%0d: got %b want %b", k, t_end, (k == 16) ? 4'b0100 : 4'b0000);
      end
    end
    p0_req = 1'b0;
    tick();
    n_cmp++;
    if (t_end !== 4'b0000) begin n_bad++; $display("FAIL tmo_pulse: got %b want 0000", t_end); end
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h70;
    tick();
    n_cmp++;
    if (t_iss !== 4'b0101) begin n_bad++; $display("FAIL tmo_idle: got %b want 0101", t_iss); end
    hx_serve(32'hCAFEF00D, 3);
    n_cmp++;
    if ({t_end, p1_rdata} !== {4'b0010, 32'hCAFEF00D}) begin
      n_bad++; $display("FAIL tmo_next: got %b %h want 0010 cafef00d", t_end, p1_rdata);
    end
    p1_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h80;
    tick();
    hx_busy = 1'b1;
    tick(); tick();
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({t_iss, t_end} !== 8'h00) begin n_bad++; $display("FAIL rst_mid_strobes: got %b want 00000000", {t_iss, t_end}); end
    n_cmp++;
    if ({hx_addr, hx_wr_d, p0_rdata, p1_rdata} !== 128'd0) begin
      n_bad++; $display("FAIL rst_mid_data: got %h %h %h %h want zeros", hx_addr, hx_wr_d, p0_rdata, p1_rdata);
    end
    p1_req = 1'b0; hx_busy = 1'b0;
    tick();
    rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if ({t_iss, t_end} !== 8'h00) begin n_bad++; $display("FAIL rst_mid_quiet%0d: got %b want 00000000", k, {t_iss, t_end}); end
    end
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h90; p0_wdata = 32'h99;
    tick();
    n_cmp++;
    if ({t_iss, hx_wr_d} !== {4'b1010, 32'h99}) begin
      n_bad++; $display("FAIL rst_mid_next: got %b %h want 1010 00000099", t_iss, hx_wr_d);
    end
    hx_serve(32'h0, 3);
    n_cmp++;
    if (t_end !== 4'b1000) begin n_bad++; $display("FAIL rst_mid_done: got %b want 1000", t_end); end
    p0_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_busy_hold();
    test_arbitration();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hram_arbiter.md
HRAM_ARBITER -- requirements
Module: hram_arbiter

Interface
REQ-001 Parameter BUSY_TMO, default 15, meaning: cycles the block waits in ARMED for hx_busy to rise before aborting; legal range 1..255.
REQ-002 clk  input  1  single clock for all logic; HyperRAM interface clock domain.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 p0_req, p1_req  input  1 each  request level; held high until pN_done or pN_err.
REQ-005 p0_we, p1_we  input  1 each  1 = write, 0 = read; sampled at grant.
REQ-006 p0_addr, p1_addr  input  32 each  word address; sampled at grant.
REQ-007 p0_wdata, p1_wdata  input  32 each  write data; sampled at grant.
REQ-008 p0_gnt, p1_gnt  output  1 each  one-cycle grant pulse.
REQ-009 p0_done, p1_done  output  1 each  one-cycle completion pulse.
REQ-010 p0_err, p1_err  output  1 each  one-cycle timeout pulse, replaces done.
REQ-011 p0_rdata, p1_rdata  output  32 each  last read data returned to that port.
REQ-012 hx_rd_req, hx_wr_req  output  1 each  one-cycle request strobes to hyper_xface.
REQ-013 hx_addr, hx_wr_d  output  32 each  address and write data to hyper_xface.
REQ-014 hx_busy  input  1  hyper_xface busy.
REQ-015 hx_rd_rdy  input  1  hyper_xface read data valid.
REQ-016 hx_rd_d  input  32  hyper_xface read data.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, ARMED, RUN, DONE; all outputs registered.
REQ-018 In IDLE, with any pN_req=1 and hx_busy=0, the FSM SHALL pick a winner, latch its we/addr/wdata into owner, hx_addr, hx_wr_d, and enter ISSUE next edge; with hx_busy=1 it SHALL remain in IDLE.
REQ-019 In ISSUE (exactly one cycle) pN_gnt of the owner SHALL be 1 and exactly one of hx_wr_req (we=1) / hx_rd_req (we=0) SHALL be 1; next state ARMED.
REQ-020 Latency: req sampled high in IDLE at edge N -> gnt and hx strobe high in cycle N+1.
REQ-021 In ARMED, hx_busy=1 -> RUN; otherwise an 8-bit counter cleared on ISSUE increments each cycle, and on reaching BUSY_TMO -> DONE with timeout flag set.
REQ-022 In RUN, each hx_rd_rdy=1 cycle on a read SHALL load hx_rd_d into the owner's pN_rdata (last one wins); hx_busy=0 -> DONE.
REQ-023 In DONE (one cycle) the owner's pN_done=1, or pN_err=1 if timed out (never both); next state IDLE.
REQ-024 Writes SHALL not alter any pN_rdata; the non-owner's outputs SHALL never change during a transaction.
REQ-025 hx_addr and hx_wr_d SHALL hold stable from ISSUE through DONE.
REQ-026 Default arbitration SHALL be round-robin: on simultaneous requests the port not served last wins; last_owner updates at ISSUE.
REQ-027 A request dropped before grant SHALL have no effect; one dropped after grant SHALL still complete normally.
REQ-028 A requester still asserting req in the cycle after DONE SHALL be treated as a new request.

Reset
REQ-029 rstn=0 SHALL asynchronously force state IDLE, all strobe outputs 0, hx_addr, hx_wr_d, p0_rdata, p1_rdata to 0, counter to 0, last_owner to 1 (p0 wins first tie).
REQ-030 Reset mid-transaction SHALL abort silently: no done/err pulse after rstn releases.

Configuration
REQ-031 With HRAM_ARB_FIXED_PRIO_EN defined, p0 SHALL win every simultaneous request and last_owner is unused; without it, round-robin per REQ-026.

Verification
REQ-032 p0 write addr 0x10, data 0xDEADBEEF; hx_busy high for 6 cycles -> p0_gnt and hx_wr_req same cycle, hx_wr_d=0xDEADBEEF, p0_done one cycle after busy falls.
REQ-033 p1 read addr 0x20, hx_rd_rdy with hx_rd_d=0x12345678 -> p1_rdata=0x12345678, p1_done pulse, p0_rdata unchanged.
REQ-034 p0 and p1 request together, held, after reset -> grants p0,p1,p0,p1 (round-robin); with HRAM_ARB_FIXED_PRIO_EN -> grants p0,p0,p0.
REQ-035 p0 read, hx_busy never rises -> p0_err exactly 15 cycles after ARMED entry, no p0_done, FSM back in IDLE.
REQ-036 rstn pulsed low during RUN -> all outputs 0 immediately, no done/err afterwards, next request serviced normally.
